// File: rtl/correlation_packetizer_if.sv
// rtl/correlation_packetizer_if.sv - byte stream handshake between the packetizer and its sink
interface correlation_packetizer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/correlation_packetizer.sv
// rtl/correlation_packetizer.sv - ASCII-hex packet of header, captured correlator payload, sequence footer; CR/LF with CORRELATION_PACKETIZER_TERMINATOR_EN
module correlation_packetizer #(
  parameter int          PAYLOAD_WIDTH = 48,
  parameter logic [63:0] HEADER_WORD   = 64'hA5A5_5A5A_0000_0001
) (
  input  logic                     pllclk,
  input  logic                     reset,
  input  logic [PAYLOAD_WIDTH-1:0] pulses,
  input  logic                     start,
  correlation_packetizer_if.master tx,
  output logic                     busy,
  output logic                     dropped
);

  localparam int PAY_NIBS = PAYLOAD_WIDTH / 4;
  localparam int MAX_NIBS = (PAY_NIBS > 16) ? PAY_NIBS : 16;
  localparam int CW       = $clog2(MAX_NIBS + 1);
  localparam int PIW      = (PAYLOAD_WIDTH > 4) ? $clog2(PAYLOAD_WIDTH) : 2;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HEADER  = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] FOOTER  = 3'd3;
`ifdef CORRELATION_PACKETIZER_TERMINATOR_EN
  localparam logic [2:0] TERM    = 3'd4;
`endif

  logic [2:0]               state;
  logic [2:0]               next_state;
  logic [CW-1:0]            nib_cnt;
  logic [PAYLOAD_WIDTH-1:0] snapshot;
  logic [63:0]              seq_cnt;
  logic [63:0]              footer_word;
  logic [5:0]               word_idx;
  logic [PIW-1:0]           pay_idx;
  logic [3:0]               nibble;
  logic                     hex_field;
  logic                     last_nib;
  logic                     fire;
  logic [7:0]               byte_out;

  // seq_cnt already counts the packet in flight, so the footer is one behind
  assign footer_word = seq_cnt - 64'd1;
  assign word_idx    = 6'd60 - 6'({nib_cnt, 2'b00});
  assign pay_idx     = PIW'(PAYLOAD_WIDTH - 4) - PIW'({nib_cnt, 2'b00});

  always_comb begin
    nibble     = 4'h0;
    hex_field  = 1'b0;
    last_nib   = 1'b0;
    next_state = IDLE;
    byte_out   = 8'h00;
    case (state)
      HEADER: begin
        nibble     = HEADER_WORD[word_idx +: 4];
        hex_field  = 1'b1;
        last_nib   = (nib_cnt == CW'(15));
        next_state = PAYLOAD;
      end
      PAYLOAD: begin
        nibble     = snapshot[pay_idx +: 4];
        hex_field  = 1'b1;
        last_nib   = (nib_cnt == CW'(PAY_NIBS - 1));
        next_state = FOOTER;
      end
      FOOTER: begin
        nibble     = footer_word[word_idx +: 4];
        hex_field  = 1'b1;
        last_nib   = (nib_cnt == CW'(15));
`ifdef CORRELATION_PACKETIZER_TERMINATOR_EN
        next_state = TERM;
`else
        next_state = IDLE;
`endif
      end
`ifdef CORRELATION_PACKETIZER_TERMINATOR_EN
      TERM: begin
        byte_out   = (nib_cnt == CW'(0)) ? 8'h0D : 8'h0A;
        last_nib   = (nib_cnt == CW'(1));
        next_state = IDLE;
      end
`endif
      default: ;
    endcase
    if (hex_field) begin
      byte_out = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    end
  end

  assign busy        = (state != IDLE);
  assign fire        = busy & tx.tx_ready;
  assign tx.tx_valid = busy;
  assign tx.tx_data  = byte_out;

  always_ff @(posedge pllclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      nib_cnt  <= '0;
      snapshot <= '0;
      seq_cnt  <= 64'd0;
      dropped  <= 1'b0;
    end else begin
      // a start is only ever honoured from IDLE, including on the final-byte edge
      dropped <= start & busy;
      if (state == IDLE) begin
        if (start) begin
          state    <= HEADER;
          nib_cnt  <= '0;
          snapshot <= pulses;
          seq_cnt  <= seq_cnt + 64'd1;
        end
      end else if (fire) begin
        if (last_nib) begin
          state   <= next_state;
          nib_cnt <= '0;
        end else begin
          nib_cnt <= nib_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_correlation_packetizer.sv
// tb/tb_correlation_packetizer.sv - scoreboard bench for correlation_packetizer at PAYLOAD_WIDTH=16
module tb_correlation_packetizer;

`ifdef CORRELATION_PACKETIZER_TERMINATOR_EN
  localparam int PKT_LEN = 38;
`else
  localparam int PKT_LEN = 36;
`endif

  logic        pllclk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pulses;
  logic        busy;
  logic        dropped;

  correlation_packetizer_if tx_bus ();

  correlation_packetizer #(.PAYLOAD_WIDTH(16)) dut (
    .pllclk  (pllclk),
    .reset   (reset),
    .pulses  (pulses),
    .start   (start),
    .tx      (tx_bus),
    .busy    (busy),
    .dropped (dropped)
  );

  always #5 pllclk = ~pllclk;

  int         checks = 0;
  int         errors = 0;
  int         xfers  = 0;
  logic [7:0] exp_q[$];
  logic       stall_pend = 1'b0;
  logic [7:0] held = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_packet(input string payload, input string footer);
    push_str("A5A55A5A00000001");
    push_str(payload);
    push_str(footer);
`ifdef CORRELATION_PACKETIZER_TERMINATOR_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic tick();
    @(posedge pllclk);
    #1;
  endtask

  // mode 0: steady, 1: scramble pulses each cycle, 2: toggle tx_ready each cycle
  task automatic end_packet(input string name, input int mode);
    int n = 0;
    while (busy && n < 400) begin
      if (mode == 1) pulses = 16'($urandom);
      if (mode == 2) tx_bus.tx_ready = ~tx_bus.tx_ready;
      tick();
      n++;
    end
    check({name, "_timeout"}, 64'(n < 400), 64'd1);
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge pllclk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", 64'(tx_bus.tx_valid), 64'd1);
        check("stall_data", 64'(tx_bus.tx_data), 64'(held));
      end
      stall_pend = tx_bus.tx_valid && !tx_bus.tx_ready;
      held       = tx_bus.tx_data;
      if (tx_bus.tx_valid && tx_bus.tx_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 64'(tx_bus.tx_data), 64'hFFFF);
        end else begin
          check("byte", 64'(tx_bus.tx_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int x0;
    reset = 1'b1;
    start = 1'b0;
    pulses = 16'h0000;
    tx_bus.tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(tx_bus.tx_valid), 64'd0);
    check("rst_data", 64'(tx_bus.tx_data), 64'h00);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);
    reset = 1'b0;
    tick();

    // packet 1: full rate, pulses scrambled after capture
    push_packet("A5F0", "0000000000000000");
    pulses = 16'hA5F0;
    tx_bus.tx_ready = 1'b1;
    x0 = xfers;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p1_latency_valid", 64'(tx_bus.tx_valid), 64'd1);
    check("p1_busy", 64'(busy), 64'd1);
    end_packet("p1", 1);
    check("p1_len", 64'(xfers - x0), 64'(PKT_LEN));
    check("p1_busy_low", 64'(busy), 64'd0);

    // packet 2: tx_ready toggling
    push_packet("A5F0", "0000000000000001");
    pulses = 16'hA5F0;
    x0 = xfers;
    start = 1'b1;
    tick();
    start = 1'b0;
    tx_bus.tx_ready = 1'b0;
    end_packet("p2", 2);
    check("p2_len", 64'(xfers - x0), 64'(PKT_LEN));

    // dropped starts at byte 10 and on the final byte
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    push_packet("1234", "0000000000000000");
    pulses = 16'h1234;
    tx_bus.tx_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1;
    pulses = 16'hFFFF;
    tick();
    start = 1'b0;
    check("drop1_pulse", 64'(dropped), 64'd1);
    tick();
    check("drop1_clear", 64'(dropped), 64'd0);
    repeat (PKT_LEN - 12) tick();
    start = 1'b1;
    tick();
    check("drop2_pulse", 64'(dropped), 64'd1);
    check("drop2_idle", 64'(busy), 64'd0);
    push_packet("FFFF", "0000000000000001");
    tick();
    start = 1'b0;
    check("reaccept_nodrop", 64'(dropped), 64'd0);
    check("reaccept_busy", 64'(busy), 64'd1);
    end_packet("p4", 0);

    // reset while stalled on byte 20
    push_packet("0F0F", "0000000000000002");
    pulses = 16'h0F0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    tx_bus.tx_ready = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(tx_bus.tx_valid), 64'd0);
    check("mid_rst_data", 64'(tx_bus.tx_data), 64'h00);
    check("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tx_bus.tx_ready = 1'b1;
    x0 = xfers;
    repeat (10) tick();
    check("no_resume", 64'(xfers - x0), 64'd0);
    check("no_resume_valid", 64'(tx_bus.tx_valid), 64'd0);

    push_packet("0009", "0000000000000000");
    pulses = 16'h0009;
    x0 = xfers;
    start = 1'b1;
    tick();
    start = 1'b0;
    end_packet("p6", 1);
    check("p6_len", 64'(xfers - x0), 64'(PKT_LEN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/correlation_packetizer.md
CORRELATION_PACKETIZER -- requirements
Module: correlation_packetizer

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 48, correlator payload width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL have parameter HEADER_WORD, default 64'hA5A5_5A5A_0000_0001, the 64-bit packet header constant.
REQ-003 SHALL have port pllclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pulses, input, PAYLOAD_WIDTH bits: the packed correlator accumulator bus.
REQ-006 SHALL have port start, input, 1 bit: packet request; sampled each cycle.
REQ-007 SHALL have port tx_ready, input, 1 bit: downstream byte sink ready.
REQ-008 SHALL have port tx_data, output, 8 bits: ASCII byte to transmit.
REQ-009 SHALL have port tx_valid, output, 1 bit: tx_data valid.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port dropped, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-012 SHALL implement states IDLE, HEADER, PAYLOAD, FOOTER and, when enabled, TERM.
- IDLE -> HEADER on start.
- HEADER -> PAYLOAD after 16 nibbles.
- PAYLOAD -> FOOTER after PAYLOAD_WIDTH/4 nibbles.
- FOOTER -> TERM, or -> IDLE, after 16 nibbles.
- TERM -> IDLE after 2 bytes.
REQ-013 On start in IDLE, SHALL capture pulses into an internal snapshot register at that edge; later changes on pulses SHALL NOT affect the packet.
REQ-014 SHALL assert tx_valid in the cycle after the accepting start edge (latency 1); tx_valid SHALL stay high continuously until the last byte of the packet transfers.
REQ-015 A byte SHALL transfer only on an edge where tx_valid and tx_ready are both 1; the next byte SHALL be presented in the following cycle.
REQ-016 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable.
REQ-017 Each nibble SHALL be sent as uppercase ASCII hex: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-018 Each field SHALL be sent most-significant nibble first.
REQ-019 Fields SHALL be sent in this order:
- HEADER_WORD;
- snapshot, bit PAYLOAD_WIDTH-1 downward;
- footer = 64-bit packet sequence number of this packet.
REQ-020 The sequence counter SHALL reset to 0, SHALL increment by 1 on each accepted start, and SHALL wrap from 2^64-1 to 0; the first packet after reset carries footer 0.
REQ-021 start while busy=1 SHALL be ignored. This includes the cycle of the final byte transfer. On such an edge, dropped SHALL pulse high for exactly one cycle, and the sequence counter and snapshot SHALL be unchanged.
REQ-022 tx_ready high while tx_valid=0 SHALL have no effect.
REQ-023 busy SHALL fall on the edge where the last byte transfers; a start in the cycle after that edge SHALL be accepted.
REQ-024 The nibble counter SHALL be wide enough for max(16, PAYLOAD_WIDTH/4) and SHALL clear on every state change.

Reset
REQ-025 Asserting reset SHALL immediately, regardless of state or pending transfer, force:
- state=IDLE;
- tx_valid=0, tx_data=0x00, busy=0, dropped=0;
- sequence counter=0, snapshot=0, nibble counter=0.
REQ-026 A packet interrupted by reset SHALL NOT resume; the first byte after reset release SHALL only follow a new start.

Configuration
REQ-027 With macro CORRELATION_PACKETIZER_TERMINATOR_EN defined, the TERM state SHALL exist and each packet SHALL end with 0x0D then 0x0A. Packet length is 34+PAYLOAD_WIDTH/4 bytes.
REQ-028 Without that macro, TERM SHALL not be built and FOOTER -> IDLE directly. Packet length is 32+PAYLOAD_WIDTH/4 bytes.

Verification (PAYLOAD_WIDTH=16, default HEADER_WORD, macro undefined unless stated)
REQ-029 Reset, then start with pulses=16'hA5F0 and tx_ready=1 -> 36 consecutive bytes: "A5A55A5A00000001", "A5F0", "0000000000000000"; busy low after byte 36.
REQ-030 Send a second packet with tx_ready toggling 1/0 each cycle -> same framing, footer "0000000000000001", tx_data stable in every stalled cycle.
REQ-031 Pulse start at byte 10 and again coincident with the last byte transfer -> dropped pulses twice; the next accepted packet carries footer 0000000000000001.
REQ-032 Assert reset at byte 20 with tx_ready=0 -> tx_valid=0 at once; after release, no bytes until a new start; that packet's footer is 0.
REQ-033 Macro defined, pulses=16'h0009 -> 38 bytes, payload "0009", final bytes 0x0D, 0x0A.
REQ-034 Change pulses every cycle during a packet -> payload bytes equal the value captured at the start edge.
